// File: rtl/shift_right_serial.sv
// Multi-cycle right shifter: shifts one bit per clock, logical or arithmetic.
// Result and last shifted-out bit are registered and held until the next start.
module shift_right_serial #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [AMT_W-1:0] amt,
    input  logic             arith,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             arith_q, arith_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            amt_q   <= '0;
            arith_q <= 1'b0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            amt_q   <= amt_d;
            arith_q <= arith_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        amt_d   = amt_q;
        arith_d = arith_q;
        f_d     = f_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x;
                    amt_d   = amt;
                    arith_d = arith;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                f_d     = x_q;
                cout_d  = 1'b0;
                cnt_d   = amt_q;
                state_d = (amt_q == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                // Sign fill only in arithmetic mode; otherwise zero fill.
                f_d    = {arith_q & f_q[WIDTH-1], f_q[WIDTH-1:1]};
                cout_d = f_q[0];
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign f    = f_q;
    assign cout = cout_q;
    assign busy = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_right_serial.sv
// Self-checking bench for shift_right_serial: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_shift_right_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [2:0] amt;
    logic       arith;
    logic [7:0] f;
    logic       cout;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    shift_right_serial #(
        .WIDTH(8),
        .AMT_W(3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .amt  (amt),
        .arith(arith),
        .f    (f),
        .cout (cout),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain division / signed shift on the whole operand.
    function automatic logic [7:0] ref_f(input logic [7:0] xv,
                                         input int av, input logic ar);
        logic signed [7:0] s;
        s = xv;
        if (ar) return 8'(s >>> av);
        return 8'(int'(xv) / (2 ** av));
    endfunction

    function automatic logic ref_c(input logic [7:0] xv, input int av);
        if (av == 0) return 1'b0;
        return 1'((int'(xv) / (2 ** (av - 1))) % 2);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one operation from IDLE; poke re-pulses start mid-operation.
    task automatic do_op(input logic [7:0] xv, input logic [2:0] av,
                         input logic ar, input bit poke, input string tag);
        int  edges;
        logic [7:0] ef;
        logic       ec;
        ef = ref_f(xv, int'(av), ar);
        ec = ref_c(xv, int'(av));
        start = 1'b1;
        x     = xv;
        amt   = av;
        arith = ar;
        tick();
        start = 1'b0;
        chk({tag, "_load_busy"}, 32'(busy), 32'd1);
        edges = 0;
        while (edges < 20) begin
            x     = 8'($urandom);
            amt   = 3'($urandom);
            arith = 1'($urandom);
            start = (poke && edges == 1) ? 1'b1 : 1'b0;
            tick();
            edges++;
            start = 1'b0;
            if (done) break;
        end
        chk({tag, "_timeout"}, 32'(done), 32'd1);
        // done visible in cycle N+amt+2, i.e. amt+1 edges after acceptance
        chk({tag, "_latency"}, 32'(edges), 32'(av) + 32'd1);
        chk({tag, "_f"}, 32'(f), 32'(ef));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'({f, cout}), 32'({ef, ec}));
    endtask

    initial begin
        logic [7:0] hf;
        logic       hc;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        x      = '0;
        amt    = '0;
        arith  = 1'b0;
        tick();
        start = 1'b1;
        x     = 8'hA5;
        amt   = 3'd2;
        tick();
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        rst   = 1'b0;

        do_op(8'b0110_0000, 3'd3, 1'b0, 1'b0, "log3");
        do_op(8'b1000_0000, 3'd7, 1'b1, 1'b0, "ari7");
        do_op(8'b1000_0000, 3'd7, 1'b0, 1'b0, "log7");
        do_op(8'h01, 3'd0, 1'b0, 1'b0, "amt0");
        do_op(8'b0000_0101, 3'd1, 1'b0, 1'b0, "cy1");
        do_op(8'b0000_0101, 3'd2, 1'b0, 1'b0, "cy2");
        do_op(8'hC3, 3'd4, 1'b0, 1'b1, "poke");

        hf = f;
        hc = cout;
        for (int i = 0; i < 4; i++) begin
            x     = 8'($urandom);
            amt   = 3'($urandom);
            arith = 1'($urandom);
            tick();
        end
        chk("idle_hold_f", 32'(f), 32'(hf));
        chk("idle_hold_c", 32'(cout), 32'(hc));
        chk("idle_busy", 32'(busy), 32'd0);

        // reset in the second SHIFT cycle, with start also high
        start = 1'b1;
        x     = 8'hF7;
        amt   = 3'd5;
        arith = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_shift", 32'(busy), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        chk("abort_f", 32'(f), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        do_op(8'h96, 3'd6, 1'b1, 1'b0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 3'($urandom), 1'($urandom),
                  1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (!rst && done && busy) begin
            checks++;
            errors++;
            $error("FAIL done_and_busy observed=1 expected=0");
        end
    end

endmodule
